// File: rtl/sad_pkg.sv
// Shared constants and state encoding for the SAD sequencer.
package sad_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StDrain,
        StCompare,
        StDone
    } sad_state_e;

    localparam int unsigned N_BIG       = 16;
    localparam int unsigned N_SMALL     = 8;

    // Four pixels per 32-bit word.
    localparam int unsigned WPR_BIG     = N_BIG / 4;
    localparam int unsigned WPR_SMALL   = N_SMALL / 4;
    localparam int unsigned WORDS_BIG   = WPR_BIG * N_BIG;
    localparam int unsigned WORDS_SMALL = WPR_SMALL * N_SMALL;

    localparam int unsigned K_W = $clog2(WORDS_BIG);
    localparam int unsigned C_W = $clog2(WPR_BIG);

    localparam logic [K_W-1:0] K_LAST_BIG   = K_W'(WORDS_BIG - 1);
    localparam logic [K_W-1:0] K_LAST_SMALL = K_W'(WORDS_SMALL - 1);
    localparam logic [C_W-1:0] C_LAST_BIG   = C_W'(WPR_BIG - 1);
    localparam logic [C_W-1:0] C_LAST_SMALL = C_W'(WPR_SMALL - 1);

endpackage

// File: rtl/sad_absdiff4.sv
// Four-lane unsigned byte |a-b| summed into a 10-bit result.
module sad_absdiff4 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [9:0]  sum_o
);

    // Per-lane absolute difference, then a flat add of the four lanes.
    always_comb begin
        logic [7:0] la;
        logic [7:0] lb;
        sum_o = '0;
        for (int i = 0; i < 4; i++) begin
            la = a_i[8*i +: 8];
            lb = b_i[8*i +: 8];
            sum_o = sum_o + 10'((la > lb) ? (la - lb) : (lb - la));
        end
    end

endmodule

// File: rtl/sad_sequencer.sv
// Multi-cycle SAD sequencer: walks an NxN window, accumulates SAD, tracks minimum.
// Optional feature macro: SAD_EARLY_EXIT_EN (abort at a row end once acc >= MinSad).
module sad_sequencer
    import sad_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned SAD_W  = 16,
    parameter int unsigned IDX_W  = 16
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              SmallBig,
    input  logic [ADDR_W-1:0] FrameBase,
    input  logic [ADDR_W-1:0] FrameStride,
    input  logic [ADDR_W-1:0] WinBase,
    input  logic [IDX_W-1:0]  CandIdx,
    input  logic              ClearMin,
    output logic [ADDR_W-1:0] FrameAddr,
    output logic [ADDR_W-1:0] WinAddr,
    output logic              MemRead,
    input  logic [31:0]       FrameData,
    input  logic [31:0]       WinData,
    output logic              Stall,
    output logic              Done,
    output logic [SAD_W-1:0]  SadOut,
    output logic [SAD_W-1:0]  MinSad,
    output logic [IDX_W-1:0]  MinIdx,
    output logic              Aborted
);

    sad_state_e        state_q, state_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] win_base_q, win_base_d;
    logic [IDX_W-1:0]  cand_q, cand_d;
    logic [IDX_W-1:0]  min_idx_q, min_idx_d;
    logic              small_q, small_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [C_W-1:0]    c_q, c_d;
    logic [SAD_W-1:0]  acc_q, acc_d;
    logic [SAD_W-1:0]  sad_q, sad_d;
    logic [SAD_W-1:0]  min_sad_q, min_sad_d;
    logic              vld_q, vld_d;

    logic [9:0]        diff;
    logic [SAD_W-1:0]  acc_sum;
    logic              last_col;
    logic              last_word;
    logic              accumulate;
    logic              early_exit;

    sad_absdiff4 u_absdiff4 (
        .a_i   (FrameData),
        .b_i   (WinData),
        .sum_o (diff)
    );

    assign last_col   = small_q ? (c_q == C_LAST_SMALL) : (c_q == C_LAST_BIG);
    assign last_word  = small_q ? (k_q == K_LAST_SMALL) : (k_q == K_LAST_BIG);
    // Read data lands one cycle after the strobe, i.e. in READ or DRAIN.
    assign accumulate = vld_q && ((state_q == StRead) || (state_q == StDrain));
    assign acc_sum    = acc_q + SAD_W'(diff);

`ifdef SAD_EARLY_EXIT_EN
    logic row_end_q, row_end_d;
    logic aborted_q, aborted_d;

    assign row_end_d  = (state_q == StRead) && last_col;
    assign early_exit = accumulate && row_end_q && (acc_sum >= min_sad_q);

    // Row-end marker travels with the read data; abort flag lives until the next Start.
    always_ff @(posedge clk) begin
        if (Reset) begin
            row_end_q <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            row_end_q <= row_end_d;
            aborted_q <= aborted_d;
        end
    end

    // Clear on launch, set on an early exit.
    always_comb begin
        aborted_d = aborted_q;
        if (state_q == StIdle && Start) begin
            aborted_d = 1'b0;
        end
        if (early_exit) begin
            aborted_d = 1'b1;
        end
    end
`else
    assign early_exit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (Start) state_d = StRead;
            StRead: begin
                if (early_exit) begin
                    state_d = StDone;
                end else if (last_word) begin
                    state_d = StDrain;
                end
            end
            StDrain:   state_d = early_exit ? StDone : StCompare;
            StCompare: state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        MemRead   = (state_q == StRead);
        Stall     = Start || (state_q != StIdle);
        Done      = (state_q == StDone);
        FrameAddr = MemRead ? (row_base_q + ADDR_W'(c_q)) : '0;
        WinAddr   = MemRead ? (win_base_q + ADDR_W'(k_q)) : '0;
`ifdef SAD_EARLY_EXIT_EN
        Aborted   = Done && aborted_q;
`else
        Aborted   = 1'b0;
`endif
    end

    assign SadOut = sad_q;
    assign MinSad = min_sad_q;
    assign MinIdx = min_idx_q;

    // Datapath next-state: operand latch, address walk, accumulation, minimum tracking.
    always_comb begin
        row_base_d = row_base_q;
        stride_d   = stride_q;
        win_base_d = win_base_q;
        cand_d     = cand_q;
        small_d    = small_q;
        k_d        = k_q;
        c_d        = c_q;
        acc_d      = acc_q;
        sad_d      = sad_q;
        min_sad_d  = min_sad_q;
        min_idx_d  = min_idx_q;
        vld_d      = MemRead;

        if (state_q == StIdle && Start) begin
            row_base_d = FrameBase;
            stride_d   = FrameStride;
            win_base_d = WinBase;
            cand_d     = CandIdx;
            small_d    = SmallBig;
            k_d        = '0;
            c_d        = '0;
            acc_d      = '0;
        end

        if (state_q == StRead) begin
            k_d = k_q + K_W'(1);
            if (last_col) begin
                c_d        = '0;
                row_base_d = row_base_q + stride_q;
            end else begin
                c_d = c_q + C_W'(1);
            end
        end

        if (accumulate) begin
            acc_d = acc_sum;
        end

        if (early_exit) begin
            sad_d = acc_sum;
        end

        // Clear first so a coinciding compare always installs the new result.
        if (ClearMin) begin
            min_sad_d = '1;
            min_idx_d = '0;
        end

        if (state_q == StCompare) begin
            sad_d = acc_q;
            if (acc_q < min_sad_d) begin
                min_sad_d = acc_q;
                min_idx_d = cand_q;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (Reset) begin
            row_base_q <= '0;
            stride_q   <= '0;
            win_base_q <= '0;
            cand_q     <= '0;
            small_q    <= 1'b0;
            k_q        <= '0;
            c_q        <= '0;
            acc_q      <= '0;
            sad_q      <= '0;
            min_sad_q  <= '1;
            min_idx_q  <= '0;
            vld_q      <= 1'b0;
        end else begin
            row_base_q <= row_base_d;
            stride_q   <= stride_d;
            win_base_q <= win_base_d;
            cand_q     <= cand_d;
            small_q    <= small_d;
            k_q        <= k_d;
            c_q        <= c_d;
            acc_q      <= acc_d;
            sad_q      <= sad_d;
            min_sad_q  <= min_sad_d;
            min_idx_q  <= min_idx_d;
            vld_q      <= vld_d;
        end
    end

endmodule
